// File: rtl/branch_resolver.sv
// branch_resolver
// EX-stage half of the 2-bit branch predictor. Holds the branch captured in ID
// for one cycle, resolves it against the EX comparator, and returns the next
// counter state, the EX_Branch strobe, and the rollback request with its
// corrected PC. Also keeps saturating branch / mispredict counters.

module branch_resolver #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_branch_i,
  input  logic              id_bne_i,
  input  logic [ADDR_W-1:0] id_pc_i,
  input  logic [ADDR_W-1:0] id_imm_i,
  input  logic [1:0]        state_i,
  input  logic              stall_i,
  input  logic              eq_i,
  output logic              ex_branch_o,
  output logic [1:0]        update_o,
  output logic              rbk_o,
  output logic [ADDR_W-1:0] rbk_addr_o,
  output logic [CNT_W-1:0]  branch_cnt_o,
  output logic [CNT_W-1:0]  mispred_cnt_o
);

  // EX-stage copy of the branch decoded in ID
  logic              r_ex_valid;
  logic              r_ex_bne;
  logic [ADDR_W-1:0] r_ex_pc;
  logic [ADDR_W-1:0] r_ex_imm;
  logic [1:0]        r_ex_state;

  logic [CNT_W-1:0]  r_branch_cnt;
  logic [CNT_W-1:0]  r_mispred_cnt;

  logic              w_capture;
  logic              w_taken;
  logic              w_pred;
  logic              w_mispred;
  logic [1:0]        w_next_state;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_fallthru;

  // A stalled ID branch stays in ID and is presented again, so it is not
  // captured now. A rollback in flight marks the ID branch as wrong-path: its
  // fields may still be loaded, but it never becomes valid in EX.
  assign w_capture = id_branch_i & ~stall_i;

  assign w_taken   = eq_i ^ r_ex_bne;
  assign w_pred    = r_ex_state[1];
  assign w_mispred = r_ex_valid & (w_taken != w_pred);

  // Immediate is in half-word units, hence the one-bit shift.
  assign w_target   = r_ex_pc + {r_ex_imm[ADDR_W-2:0], 1'b0};
  assign w_fallthru = r_ex_pc + ADDR_W'(4);

  // Saturating 2-bit counter step in the resolved direction
  always_comb begin
    w_next_state = r_ex_state;
    if (w_taken) begin
      if (r_ex_state != 2'b11) w_next_state = r_ex_state + 2'b01;
    end else begin
      if (r_ex_state != 2'b00) w_next_state = r_ex_state - 2'b01;
    end
  end

  // ID->EX pipeline register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ex_valid <= 1'b0;
      r_ex_bne   <= 1'b0;
      r_ex_pc    <= '0;
      r_ex_imm   <= '0;
      r_ex_state <= 2'b11;
    end else begin
      r_ex_valid <= w_capture & ~w_mispred;
      if (w_capture) begin
        r_ex_bne   <= id_bne_i;
        r_ex_pc    <= id_pc_i;
        r_ex_imm   <= id_imm_i;
        r_ex_state <= state_i;
      end
    end
  end

  // Performance counters, saturating at all-ones
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (r_ex_valid && (r_branch_cnt != {CNT_W{1'b1}}))
        r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      if (w_mispred && (r_mispred_cnt != {CNT_W{1'b1}}))
        r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
    end
  end

  assign ex_branch_o   = r_ex_valid;
  assign rbk_o         = w_mispred;
  // With no branch in EX the predictor ignores update_o; hold the stored state.
  assign update_o      = r_ex_valid ? w_next_state : r_ex_state;
  assign rbk_addr_o    = r_ex_valid ? (w_taken ? w_target : w_fallthru) : '0;
  assign branch_cnt_o  = r_branch_cnt;
  assign mispred_cnt_o = r_mispred_cnt;

endmodule

// File: tb/tb_branch_resolver.sv
// Testbench for branch_resolver: directed vector table, hand-written
// saturation / reset sequences, and randomized traffic against a model.

module tb_branch_resolver;

  logic        clk;
  logic        rst, idb, bne, stall, eq;
  logic [31:0] pc, imm;
  logic [1:0]  st;

  logic        exb, rbk;
  logic [1:0]  upd;
  logic [31:0] addr, bcnt, mcnt;
  logic        exb4, rbk4;
  logic [1:0]  upd4;
  logic [31:0] addr4;
  logic [3:0]  bcnt4, mcnt4;

  int n_checks = 0;
  int n_pass   = 0;

  branch_resolver #(.ADDR_W(32), .CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .id_branch_i(idb), .id_bne_i(bne),
    .id_pc_i(pc), .id_imm_i(imm), .state_i(st), .stall_i(stall), .eq_i(eq),
    .ex_branch_o(exb), .update_o(upd), .rbk_o(rbk), .rbk_addr_o(addr),
    .branch_cnt_o(bcnt), .mispred_cnt_o(mcnt)
  );

  branch_resolver #(.ADDR_W(32), .CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .id_branch_i(idb), .id_bne_i(bne),
    .id_pc_i(pc), .id_imm_i(imm), .state_i(st), .stall_i(stall), .eq_i(eq),
    .ex_branch_o(exb4), .update_o(upd4), .rbk_o(rbk4), .rbk_addr_o(addr4),
    .branch_cnt_o(bcnt4), .mispred_cnt_o(mcnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input bit r, input bit b, input bit n, input logic [31:0] p,
                       input logic [31:0] i, input logic [1:0] s, input bit sl, input bit e);
    rst = r; idb = b; bne = n; pc = p; imm = i; st = s; stall = sl; eq = e;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          chk;
    bit          rst, idb, bne;
    logic [31:0] pc, imm;
    logic [1:0]  st;
    bit          stall, eq;
    bit          e_exb, e_rbk;
    logic [1:0]  e_upd;
    logic [31:0] e_addr;
    int          e_b, e_m;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(bit c, bit r, bit b, bit n, logic [31:0] p, logic [31:0] i,
                             logic [1:0] s, bit sl, bit e, bit xb, bit rb, logic [1:0] u,
                             logic [31:0] a, int cb, int cm);
    vec_t t;
    t.chk = c; t.rst = r; t.idb = b; t.bne = n; t.pc = p; t.imm = i; t.st = s;
    t.stall = sl; t.eq = e; t.e_exb = xb; t.e_rbk = rb; t.e_upd = u; t.e_addr = a;
    t.e_b = cb; t.e_m = cm;
    return t;
  endfunction

  // Behavioural reference: one branch slot between ID and EX plus counters.
  bit          m_valid, m_bne;
  logic [31:0] m_pc, m_imm;
  int          m_state;
  longint      m_b, m_m, m_b4, m_m4;

  function automatic bit m_mis();
    bit tk;
    tk = (eq != m_bne);
    return m_valid && (tk != (m_state >= 2));
  endfunction

  task automatic model_reset();
    m_valid = 0; m_bne = 0; m_pc = 0; m_imm = 0; m_state = 3;
    m_b = 0; m_m = 0; m_b4 = 0; m_m4 = 0;
  endtask

  task automatic model_check();
    bit          tk;
    int          nxt;
    logic [31:0] ea;
    tk  = (eq != m_bne);
    nxt = tk ? ((m_state < 3) ? m_state + 1 : 3) : ((m_state > 0) ? m_state - 1 : 0);
    if (!m_valid) ea = 32'h0;
    else if (tk)  ea = m_pc + m_imm * 32'd2;
    else          ea = m_pc + 32'd4;
    chk("rnd_ex_branch", exb, m_valid);
    chk("rnd_rbk", rbk, m_mis());
    chk("rnd_update", upd, m_valid ? nxt : m_state);
    chk("rnd_rbk_addr", addr, ea);
    chk("rnd_branch_cnt", bcnt, m_b);
    chk("rnd_mispred_cnt", mcnt, m_m);
    chk("rnd_branch_cnt4", bcnt4, m_b4);
    chk("rnd_mispred_cnt4", mcnt4, m_m4);
  endtask

  // Advance the model across the clock edge using the inputs held at that edge.
  task automatic model_step(input bit r, input bit b, input bit n, input logic [31:0] p,
                            input logic [31:0] i, input logic [1:0] s, input bit sl,
                            input bit mis);
    if (r) begin
      model_reset();
    end else begin
      if (m_valid) begin
        if (m_b < 64'hFFFF_FFFF) m_b++;
        if (m_b4 < 15) m_b4++;
      end
      if (mis) begin
        if (m_m < 64'hFFFF_FFFF) m_m++;
        if (m_m4 < 15) m_m4++;
      end
      m_valid = b && !sl && !mis;
      if (b && !sl) begin
        m_bne = n; m_pc = p; m_imm = i; m_state = s;
      end
    end
  endtask

  initial begin
    bit mis;
    drive(1, 0, 0, 0, 0, 0, 0, 0);

    //         chk rst idb bne pc          imm           st    stl eq  exb rbk upd   addr          b  m
    tbl.push_back(v(0, 1, 0, 0, 32'h0,   32'h0,        2'b00, 0, 0, 0, 0, 2'b11, 32'h0,        0, 0));
    tbl.push_back(v(1, 1, 0, 0, 32'h0,   32'h0,        2'b00, 0, 0, 0, 0, 2'b11, 32'h0,        0, 0));
    tbl.push_back(v(1, 0, 1, 0, 32'h100, 32'h8,        2'b11, 0, 0, 0, 0, 2'b11, 32'h0,        0, 0));
    tbl.push_back(v(1, 0, 0, 0, 32'h0,   32'h0,        2'b00, 0, 1, 1, 0, 2'b11, 32'h110,      0, 0));
    tbl.push_back(v(1, 0, 1, 0, 32'h100, 32'h8,        2'b01, 0, 0, 0, 0, 2'b11, 32'h0,        1, 0));
    tbl.push_back(v(1, 0, 1, 0, 32'h300, 32'h4,        2'b11, 0, 1, 1, 1, 2'b10, 32'h110,      1, 0));
    tbl.push_back(v(1, 0, 0, 0, 32'h0,   32'h0,        2'b00, 0, 1, 0, 0, 2'b11, 32'h0,        2, 1));
    tbl.push_back(v(1, 0, 1, 1, 32'h200, 32'h20,       2'b10, 0, 0, 0, 0, 2'b11, 32'h0,        2, 1));
    tbl.push_back(v(1, 0, 0, 0, 32'h0,   32'h0,        2'b00, 0, 1, 1, 1, 2'b01, 32'h204,      2, 1));
    tbl.push_back(v(1, 0, 1, 1, 32'h200, 32'h20,       2'b00, 0, 0, 0, 0, 2'b10, 32'h0,        3, 2));
    tbl.push_back(v(1, 0, 1, 0, 32'h400, 32'h10,       2'b11, 0, 1, 1, 0, 2'b00, 32'h204,      3, 2));
    tbl.push_back(v(1, 0, 1, 0, 32'h0,   32'hFFFF_FFFC, 2'b00, 1, 1, 1, 0, 2'b11, 32'h420,     4, 2));
    tbl.push_back(v(1, 0, 1, 0, 32'h0,   32'hFFFF_FFFC, 2'b00, 0, 0, 0, 0, 2'b11, 32'h0,       5, 2));
    tbl.push_back(v(1, 0, 0, 0, 32'h0,   32'h0,        2'b00, 0, 1, 1, 1, 2'b01, 32'hFFFF_FFF8, 5, 2));
    tbl.push_back(v(1, 0, 0, 0, 32'h0,   32'h0,        2'b00, 0, 0, 0, 0, 2'b00, 32'h0,        6, 3));

    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].rst, tbl[k].idb, tbl[k].bne, tbl[k].pc, tbl[k].imm, tbl[k].st,
            tbl[k].stall, tbl[k].eq);
      #1;
      if (tbl[k].chk) begin
        chk($sformatf("tbl%0d_ex_branch", k), exb, tbl[k].e_exb);
        chk($sformatf("tbl%0d_rbk", k), rbk, tbl[k].e_rbk);
        chk($sformatf("tbl%0d_update", k), upd, tbl[k].e_upd);
        chk($sformatf("tbl%0d_rbk_addr", k), addr, tbl[k].e_addr);
        chk($sformatf("tbl%0d_branch_cnt", k), bcnt, tbl[k].e_b);
        chk($sformatf("tbl%0d_mispred_cnt", k), mcnt, tbl[k].e_m);
      end
      tick();
    end

    // 20 mispredicts: counters saturate on the 4-bit instance only
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int k = 0; k < 20; k++) begin
      drive(0, 1, 0, 32'h1000 + 32'(k * 16), 32'h40, 2'b00, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      #1;
      if (k == 19) chk("sat_last_rbk", rbk4, 1'b1);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("sat_mispred_cnt4", mcnt4, 4'hF);
    chk("sat_branch_cnt4", bcnt4, 4'hF);
    chk("sat_mispred_cnt32", mcnt, 20);
    chk("sat_branch_cnt32", bcnt, 20);

    // Reset while a mispredict is pending in EX: no rollback afterwards
    drive(0, 1, 0, 32'h80, 32'h10, 2'b00, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("rstmid_pending_rbk", rbk, 1'b1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("rstmid_rbk", rbk, 1'b0);
    chk("rstmid_ex_branch", exb, 1'b0);
    chk("rstmid_mispred_cnt4", mcnt4, 4'h0);
    chk("rstmid_branch_cnt4", bcnt4, 4'h0);
    chk("rstmid_mispred_cnt32", mcnt, 0);
    tick();

    // Randomized traffic against the reference model
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    model_reset();
    for (int k = 0; k < 2000; k++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
            $urandom, $urandom, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
            $urandom_range(0, 1));
      #1;
      model_check();
      mis = m_mis();
      tick();
      model_step(rst, idb, bne, pc, imm, st, stall, mis);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
